rf_write_arbiter: RTL
=====================

# rf_write_arbiter

Shares the register file's single write port between the processor and up to `NREQ` hardware requesters, such as game-logic score injection and button/LED status words. The processor always has priority. Hardware requesters are served round-robin in the cycles the processor does not write. An optional starvation guard stalls the processor when a hardware requester has waited too long. The block sits between the processor's regfile write outputs and the regfile, all in the processor clock domain.

## Interface
- `NREQ`, 4: number of hardware requesters, 1..8.
- `STARVE_LIMIT`, 8: wait cycles (1..255) after which a pending requester counts as starved.
- `clk`  in  1  processor clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_we`  in  1  processor write enable.
- `cpu_rd`  in  5  processor destination register.
- `cpu_data`  in  32  processor write data.
- `hw_req`  in  NREQ  per-requester write request, level, held until acked.
- `hw_rd`  in  5*NREQ  destination register; requester i uses bits [5i+4:5i].
- `hw_data`  in  32*NREQ  write data; requester i uses bits [32i+31:32i].
- `hw_ack`  out  NREQ  one-hot; high in the cycle requester i's write is performed.
- `rf_we`  out  1  regfile write enable.
- `rf_rd`  out  5  regfile destination register.
- `rf_data`  out  32  regfile write data.
- `stall_cpu`  out  1  registered processor stall request.

## Operation
- Port mux is combinational, in the same cycle.
  - If `cpu_we`=1 and `stall_cpu`=0: pass the CPU write through; `hw_ack`=0.
  - Otherwise, if any `hw_req` is set: grant the first set bit at or after `rr_ptr`, circular search. Drive that requester's rd/data and assert its `hw_ack` bit.
  - Otherwise: `rf_we`=0, `rf_rd`=0, `rf_data`=0.
- Write to r0 by a requester: acked normally, but `rf_we` is forced to 0. A CPU write to r0 is passed through unchanged; the regfile ignores it.
- `rr_ptr` (clog2(NREQ) bits, reset 0): on any hw grant, becomes granted index+1, wrapping at NREQ-1 -> 0. Otherwise unchanged.
- Requester handshake:
  - Requester keeps `hw_req`, `hw_rd`, `hw_data` stable until the cycle `hw_ack` is high.
  - It may raise `hw_req` again for a new write in the very next cycle.
  - Dropping `hw_req` before ack is legal and cancels the request; nothing is written.
- Wait counters: one 8-bit counter per requester, reset 0.
  - Increments, saturating at 255, each cycle its `hw_req`=1 and `hw_ack`=0.
  - Clears when ack is high or `hw_req`=0.
- Starvation guard (only with macro, see Configuration):
  - `stall_cpu` is set at the edge where any wait counter ≥ STARVE_LIMIT.
  - It clears at the edge after the cycle in which a starved requester was acked, provided no other counter is ≥ STARVE_LIMIT.
  - While `stall_cpu`=1, `cpu_we` is ignored by the mux. The processor contract is that a stalled processor holds its pending write, which is performed after the stall drops.
- Reset mid-operation: `reset_n` low immediately forces all outputs to 0, `rr_ptr` to 0, counters to 0 and `stall_cpu` to 0. Pending requests are not remembered; requesters must re-present them.

## Timing
- Write latency is 0 cycles: `rf_*` reflects the granted source in the same cycle, and the regfile captures it at the next rising edge.
- `hw_ack` is combinational, coincident with `rf_we` for that write.
- Minimum hardware throughput is one write per cycle when `cpu_we`=0.
- Fairness: with the CPU idle and all NREQ requesting continuously, each requester is acked once every NREQ cycles.
- `stall_cpu` asserts exactly 1 cycle after the counter reaches STARVE_LIMIT. Worst-case wait with the guard enabled is STARVE_LIMIT+NREQ cycles.
- Reset values of every output: `hw_ack`=0, `rf_we`=0, `rf_rd`=0, `rf_data`=0, `stall_cpu`=0.

## Configuration
- `RF_ARB_STARVE_STALL_EN` defined: wait counters drive `stall_cpu` as described, giving a bounded wait for hardware requesters.
- Not defined: `stall_cpu` is tied to 0 and the wait counters are not built. The processor has strict priority, so a requester can wait indefinitely while `cpu_we` stays high.

## Test plan
- CPU only: `cpu_we`=1, rd=5, data=0x1234, no hw_req -> rf_we=1, rf_rd=5, rf_data=0x1234 the same cycle; hw_ack=0.
- Round-robin: CPU idle, hw_req=4'b1111, each requester with a distinct rd (26..29) -> acks 0,1,2,3,0 on consecutive cycles, with rf_rd matching each.
- Priority collision: `cpu_we`=1 (rd=3) together with hw_req[1]=1 (rd=30, data=1) -> CPU written first. With the CPU idle the next cycle -> hw_ack=4'b0010, rf_rd=30, rf_data=1.
- r0 suppression: hw_req[2]=1 with rd=0 -> hw_ack[2]=1, rf_we=0.
- Starvation, with the macro defined and STARVE_LIMIT=8: `cpu_we` held high with hw_req[0]=1 -> stall_cpu rises on the 9th cycle and hw_ack[0] in that cycle; stall_cpu falls the next cycle. Without the macro, stall_cpu stays 0 for 100 cycles.
- Reset mid-request: hw_req=4'b0110 with rr_ptr=2, then reset_n pulsed low mid-cycle -> outputs 0 immediately. After release, requester 1 is acked first because rr_ptr is back at 0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Shares the regfile write port between the processor (strict priority) and NREQ
// round-robin hardware requesters. Optional starvation guard: RF_ARB_STARVE_STALL_EN.
module rf_write_arbiter #(
  parameter int NREQ         = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_we,
  input  logic [4:0]         cpu_rd,
  input  logic [31:0]        cpu_data,
  input  logic [NREQ-1:0]    hw_req,
  input  logic [5*NREQ-1:0]  hw_rd,
  input  logic [32*NREQ-1:0] hw_data,
  output logic [NREQ-1:0]    hw_ack,
  output logic               rf_we,
  output logic [4:0]         rf_rd,
  output logic [31:0]        rf_data,
  output logic               stall_cpu
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
    $error("rf_write_arbiter: NREQ must be 1..8");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("rf_write_arbiter: STARVE_LIMIT must be 1..255");
  end

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_ptr_d;
  logic [PW-1:0] grant_idx;
  logic          grant_valid;
  logic          cpu_sel;
  logic          hw_grant;
  logic [4:0]    grant_rd;
  logic [31:0]   grant_data;

  // Circular search from rr_ptr. Iterating downwards lets the smallest offset
  // overwrite the others, so no early exit is needed.
  always_comb begin
    int idx;
    // NOTE: every combinationally assigned variable gets a default first;
    // a path that leaves one unassigned would infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (hw_req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  assign cpu_sel    = cpu_we & ~stall_cpu;
  assign hw_grant   = reset_n & ~cpu_sel & grant_valid;
  assign grant_rd   = hw_rd[int'(grant_idx)*5 +: 5];
  assign grant_data = hw_data[int'(grant_idx)*32 +: 32];

  // Port mux. Outputs are gated by reset_n so an asserted reset zeroes them
  // immediately, even while requesters still hold hw_req.
  always_comb begin
    hw_ack  = '0;
    rf_we   = 1'b0;
    rf_rd   = '0;
    rf_data = '0;
    if (reset_n) begin
      if (cpu_sel) begin
        rf_we   = 1'b1;
        rf_rd   = cpu_rd;
        rf_data = cpu_data;
      end else if (grant_valid) begin
        hw_ack[grant_idx] = 1'b1;
        rf_rd             = grant_rd;
        rf_data           = grant_data;
        // r0 is hardwired zero: ack the requester but suppress the write.
        rf_we             = (grant_rd != 5'd0);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr;
    if (hw_grant) begin
      rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr <= '0;
    else          rr_ptr <= rr_ptr_d;
  end

`ifdef RF_ARB_STARVE_STALL_EN
  logic [7:0] wait_cnt   [NREQ];
  logic [7:0] wait_cnt_d [NREQ];
  logic       starve_d;

  // The stall is registered from the next-state counters, so it rises in the
  // cycle after a counter's update reaches STARVE_LIMIT and drops right after
  // the starved requester is served.
  always_comb begin
    starve_d = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hw_req[i] || hw_ack[i]) wait_cnt_d[i] = 8'd0;
      else if (wait_cnt[i] != 8'hff) wait_cnt_d[i] = wait_cnt[i] + 8'd1;
      else                           wait_cnt_d[i] = wait_cnt[i];
      if (wait_cnt_d[i] >= 8'(STARVE_LIMIT)) starve_d = 1'b1;
    end
  end

  // NOTE: the counter array is small control state and must start at zero,
  // so it is reset element by element (unlike a data memory, which is not).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= 8'd0;
      stall_cpu <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= wait_cnt_d[i];
      stall_cpu <= starve_d;
    end
  end
`else
  assign stall_cpu = 1'b0;
`endif

endmodule
